mem_bus_sequencer: RTL and testbench
====================================

Name: mem_bus_sequencer

Overview:
Parametrised external-memory bus cycle generator. It replaces the fixed fetch timing hard-wired in the control unit with a reusable sequencer. It runs read cycles (instruction fetch, load) and write cycles (store) on the multiplexed address/data bus using the ALE/nME/nOE/nWE/ENB strobes. Adds programmable wait states, a Ready handshake from slow memory, a bus timeout and back-to-back requests; the control FSM issues Req and stalls on Busy until Ack.

Parameters:
DATA_W, 16, width of the address/data bus, ReqAddr, ReqWData, RData.
WAIT_STATES, 0, extra ACCESS cycles inserted unconditionally (0..15).
TIMEOUT, 0, max ACCESS cycles with Ready low after wait states expire; 0 = no timeout (wait forever).

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
Req  in  1  transfer request; sampled in IDLE and DONE
ReqWrite  in  1  1 = write, 0 = read; captured with Req
ReqAddr  in  DATA_W  transfer address; captured with Req
ReqWData  in  DATA_W  write data; captured with Req
Busy  out  1  high in every state except IDLE
Ack  out  1  one-cycle completion pulse (DONE state)
Err  out  1  valid with Ack: transfer ended by timeout
RData  out  DATA_W  read data; holds until next successful read
Ready  in  1  memory ready; only sampled in ACCESS
AdOut  out  DATA_W  value driven on the AD bus
AdIn  in  DATA_W  value sampled from the AD bus
ENB  out  1  AD pad output enable (1 = drive AdOut)
ALE  out  1  address latch enable
nME  out  1  memory enable, active low
nOE  out  1  output enable, active low
nWE  out  1  write enable, active low

Behaviour:
- Reset (sync, wins over everything): state IDLE; ALE=0, nME=1, nOE=1, nWE=1, ENB=0, Ack=0, Err=0, Busy=0, RData=0, AdOut=0. A transfer in progress is aborted with no Ack and all strobes inactive on the next cycle.
- The request is registered on acceptance. ReqAddr, ReqWData and ReqWrite are ignored at all other times.
- States and outputs (all outputs registered/Moore):
  IDLE: all strobes inactive, ENB=0. If Req=1, go to ADDR.
  ADDR: AdOut=addr, ENB=1, ALE=0, nME=1. Go to LATCH.
  LATCH: AdOut=addr, ENB=1, ALE=1. Go to TURN.
  TURN: ALE=0, nME=0. Write: AdOut=wdata, ENB=1. Read: ENB=0 (bus turnaround). Go to ACCESS.
  ACCESS: nME=0. Read: nOE=0. Write: nWE=0, ENB=1 with wdata.
   - The counter counts ACCESS cycles.
   - Leave to DONE at the first edge where at least 1+WAIT_STATES cycles have elapsed and Ready=1. For a read, RData<=AdIn on that edge.
   - If TIMEOUT>0 and Ready has been low for TIMEOUT cycles after the wait states expire, go to DONE with Err=1. RData is not updated.
  DONE: nOE=nWE=1, nME=1, ENB=0, Ack=1, Err as set. If Req=1, capture the new request and go to ADDR; otherwise go to IDLE.
- Latency (WAIT_STATES=0, Ready=1): Req sampled at edge 0 gives Ack high in cycle 5. Each wait state or Ready-low cycle adds one cycle. Back-to-back throughput is one transfer per 5+W cycles.
- Counter width: clog2(WAIT_STATES+TIMEOUT+2). It saturates and never wraps.
- Ready changes outside ACCESS have no effect. Err clears on leaving DONE.
- ALE and nOE/nWE are never low/high concurrently: ALE=1 only in LATCH, and nOE/nWE=0 only in ACCESS.

Test Plan:
- Read, W=0, Ready=1, ReqAddr=0x1234, AdIn=0xBEEF in ACCESS -> ALE=1 only in cycle 2 with AdOut=0x1234; nOE=0 only in cycle 4; Ack=1 cycle 5; RData=0xBEEF; Err=0.
- Write, WAIT_STATES=2, addr 0x00A0, data 0x5A5A -> ENB=1 cycles 1–6; nWE=0 cycles 4–6 with AdOut=0x5A5A; nOE stays 1; Ack cycle 7.
- Read with Ready low for first 3 ACCESS cycles (W=0) -> nOE=0 for 4 cycles; Ack in cycle 8; RData = AdIn of cycle 7.
- TIMEOUT=4, Ready held 0 -> nOE=0 for 5 cycles; Ack=1 and Err=1 together; RData keeps its previous value 0xBEEF.
- Req held high for 3 reads -> Ack pulses exactly 5 cycles apart; no IDLE cycle between transfers; each address appears once on ALE.
- Reset=1 during ACCESS of a write -> next cycle nWE=1, nME=1, ENB=0, Busy=0, no Ack; a new read then completes normally.

Source files
------------

// File: rtl/mem_bus_sequencer.sv
// ---------------------------------------------------------------------------
// mem_bus_sequencer
//
// Bus cycle generator for an external memory on a multiplexed address/data
// bus. A requester raises Req, sees Busy while the transfer is in flight,
// and gets a one-cycle Ack, with Err set if the transfer timed out.
//
// Each transfer walks ADDR -> LATCH -> TURN -> ACCESS -> DONE:
//   ADDR   drive the address on the AD bus
//   LATCH  pulse ALE so the external latch captures the address
//   TURN   assert nME; for a read, release the bus (ENB=0) to turn it around
//   ACCESS assert nOE (read) or nWE (write). Stay here for at least
//          1+WAIT_STATES cycles, then until Ready=1 or the timeout expires.
//   DONE   strobes inactive, Ack=1. A new request may be accepted here,
//          so back-to-back transfers skip IDLE.
//
// Every output is a flop. Its next value is decoded from the next state,
// which keeps the outputs Moore and glitch-free.
//
// Parameters:
//   DATA_W       width of the address/data bus
//   WAIT_STATES  extra ACCESS cycles inserted unconditionally (0..15)
//   TIMEOUT      ACCESS cycles with Ready low, after the wait states, before
//                the transfer is abandoned with Err=1 (0 = wait forever)
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   Req, ReqWrite        request strobe and direction (1 = write)
//   ReqAddr, ReqWData    address and write data, captured when Req is taken
//   Busy, Ack, Err       requester handshake
//   RData                data from the last successful read
//   Ready                memory ready, only looked at in ACCESS
//   AdOut, AdIn, ENB     AD pad: drive value, sampled value, output enable
//   ALE, nME, nOE, nWE   memory strobes
// ---------------------------------------------------------------------------
module mem_bus_sequencer #(
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              ReqWrite,
  input  logic [DATA_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              Busy,
  output logic              Ack,
  output logic              Err,
  output logic [DATA_W-1:0] RData,
  input  logic              Ready,
  output logic [DATA_W-1:0] AdOut,
  input  logic [DATA_W-1:0] AdIn,
  output logic              ENB,
  output logic              ALE,
  output logic              nME,
  output logic              nOE,
  output logic              nWE
);

  // The counter has to reach WAIT_STATES+TIMEOUT+1 and then saturate.
  localparam int CNT_W = $clog2(WAIT_STATES + TIMEOUT + 2);
  localparam int ELP_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam logic [ELP_W-1:0] WAIT_LIMIT    = ELP_W'(WAIT_STATES + 1);
  localparam logic [ELP_W-1:0] TIMEOUT_LIMIT = ELP_W'(WAIT_STATES + TIMEOUT + 1);
  localparam bit               TIMEOUT_EN    = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_TURN,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Registered copy of the accepted request.
  logic              write_q, write_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // ACCESS cycle counter and its derived conditions.
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ELP_W-1:0]  elapsed;
  logic              wait_done;
  logic              timeout_hit;

  // Registered outputs.
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ad_out_q, ad_out_d;
  logic              enb_q, enb_d;
  logic              ale_q, ale_d;
  logic              nme_q, nme_d;
  logic              noe_q, noe_d;
  logic              nwe_q, nwe_d;

  // elapsed counts the current ACCESS cycle too. So the first ACCESS cycle
  // has elapsed = 1, and a zero-wait transfer can finish on it.
  always_comb begin
    elapsed     = {1'b0, cnt_q} + ELP_W'(1);
    wait_done   = (elapsed >= WAIT_LIMIT);
    timeout_hit = TIMEOUT_EN && !Ready && (elapsed >= TIMEOUT_LIMIT);
  end

  // Next-state logic, request capture, counter and read-data update.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = '0;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          write_d = ReqWrite;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          state_d = S_ADDR;
        end
      end

      S_ADDR:  state_d = S_LATCH;
      S_LATCH: state_d = S_TURN;
      S_TURN:  state_d = S_ACCESS;

      S_ACCESS: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (wait_done && Ready) begin
          state_d = S_DONE;
          if (!write_q) begin
            rdata_d = AdIn;
          end
        end else if (timeout_hit) begin
          // Abandon the transfer. RData keeps the last good read.
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end

      S_DONE: begin
        if (Req) begin
          write_d = ReqWrite;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state and the next request. AdOut holds its
  // value wherever the bus is not driven, so it does not toggle needlessly.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    ack_d    = (state_d == S_DONE);
    ale_d    = (state_d == S_LATCH);
    nme_d    = !((state_d == S_TURN) || (state_d == S_ACCESS));
    noe_d    = !((state_d == S_ACCESS) && !write_d);
    nwe_d    = !((state_d == S_ACCESS) && write_d);
    enb_d    = 1'b0;
    ad_out_d = ad_out_q;

    case (state_d)
      S_ADDR, S_LATCH: begin
        enb_d    = 1'b1;
        ad_out_d = addr_d;
      end
      S_TURN, S_ACCESS: begin
        if (write_d) begin
          enb_d    = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      default: begin
        enb_d = 1'b0;
      end
    endcase
  end

  // Single state/output register. Reset aborts any transfer: no Ack, and
  // every strobe goes inactive on the following cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ad_out_q <= '0;
      enb_q    <= 1'b0;
      ale_q    <= 1'b0;
      nme_q    <= 1'b1;
      noe_q    <= 1'b1;
      nwe_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      ad_out_q <= ad_out_d;
      enb_q    <= enb_d;
      ale_q    <= ale_d;
      nme_q    <= nme_d;
      noe_q    <= noe_d;
      nwe_q    <= nwe_d;
    end
  end

  assign Busy  = busy_q;
  assign Ack   = ack_q;
  assign Err   = err_q;
  assign RData = rdata_q;
  assign AdOut = ad_out_q;
  assign ENB   = enb_q;
  assign ALE   = ale_q;
  assign nME   = nme_q;
  assign nOE   = noe_q;
  assign nWE   = nwe_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_sequencer
//
// Directed bench for mem_bus_sequencer with two instances:
//   dut_a  WAIT_STATES=0, TIMEOUT=4  (read, timeout, Ready-low, back-to-back)
//   dut_b  WAIT_STATES=2, TIMEOUT=0  (write with wait states, reset abort)
// Cycle n means the cycle after the n-th rising edge following the edge
// where Req was sampled. Outputs are sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_sequencer;

  logic        clock = 1'b0;
  logic        reset;

  logic        req_a, req_write_a, ready_a;
  logic [15:0] req_addr_a, req_wdata_a, ad_in_a;
  logic        busy_a, ack_a, err_a, enb_a, ale_a, nme_a, noe_a, nwe_a;
  logic [15:0] rdata_a, ad_out_a;

  logic        req_b, req_write_b, ready_b;
  logic [15:0] req_addr_b, req_wdata_b, ad_in_b;
  logic        busy_b, ack_b, err_b, enb_b, ale_b, nme_b, noe_b, nwe_b;
  logic [15:0] rdata_b, ad_out_b;

  int          checks   = 0;
  int          failures = 0;

  logic [15:0] b2b_addr [3];

  mem_bus_sequencer #(.DATA_W(16), .WAIT_STATES(0), .TIMEOUT(4)) dut_a (
    .Clock(clock), .Reset(reset), .Req(req_a), .ReqWrite(req_write_a),
    .ReqAddr(req_addr_a), .ReqWData(req_wdata_a), .Busy(busy_a), .Ack(ack_a),
    .Err(err_a), .RData(rdata_a), .Ready(ready_a), .AdOut(ad_out_a),
    .AdIn(ad_in_a), .ENB(enb_a), .ALE(ale_a), .nME(nme_a), .nOE(noe_a),
    .nWE(nwe_a)
  );

  mem_bus_sequencer #(.DATA_W(16), .WAIT_STATES(2), .TIMEOUT(0)) dut_b (
    .Clock(clock), .Reset(reset), .Req(req_b), .ReqWrite(req_write_b),
    .ReqAddr(req_addr_b), .ReqWData(req_wdata_b), .Busy(busy_b), .Ack(ack_b),
    .Err(err_b), .RData(rdata_b), .Ready(ready_b), .AdOut(ad_out_b),
    .AdIn(ad_in_b), .ENB(enb_b), .ALE(ale_b), .nME(nme_b), .nOE(noe_b),
    .nWE(nwe_b)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive a request onto one instance (sel_b=0 -> dut_a, 1 -> dut_b).
  task automatic applyStimulus(input bit sel_b, input logic req,
                               input logic write, input logic [15:0] addr,
                               input logic [15:0] wdata);
    if (sel_b) begin
      req_b = req; req_write_b = write; req_addr_b = addr; req_wdata_b = wdata;
    end else begin
      req_a = req; req_write_a = write; req_addr_a = addr; req_wdata_a = wdata;
    end
  endtask

  initial begin
    reset   = 1'b1;
    ready_a = 1'b1; ad_in_a = 16'h0000;
    ready_b = 1'b1; ad_in_b = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // ---------------- reset state ----------------
    tick();
    tick();
    checkOutput("rst_busy",  busy_a,   0);
    checkOutput("rst_ack",   ack_a,    0);
    checkOutput("rst_err",   err_a,    0);
    checkOutput("rst_nme",   nme_a,    1);
    checkOutput("rst_noe",   noe_a,    1);
    checkOutput("rst_nwe",   nwe_a,    1);
    checkOutput("rst_ale",   ale_a,    0);
    checkOutput("rst_enb",   enb_a,    0);
    checkOutput("rst_rdata", rdata_a,  0);
    checkOutput("rst_adout", ad_out_b, 0);
    reset = 1'b0;
    tick();

    // ---------------- single read, W=0, Ready=1 ----------------
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);
    ad_in_a = 16'hBEEF;
    tick();                                       // cycle 1 ADDR
    applyStimulus(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    checkOutput("rd_c1_busy",  busy_a,   1);
    checkOutput("rd_c1_enb",   enb_a,    1);
    checkOutput("rd_c1_ale",   ale_a,    0);
    checkOutput("rd_c1_nme",   nme_a,    1);
    checkOutput("rd_c1_adout", ad_out_a, 16'h1234);
    tick();                                       // cycle 2 LATCH
    checkOutput("rd_c2_ale",   ale_a,    1);
    checkOutput("rd_c2_adout", ad_out_a, 16'h1234);
    checkOutput("rd_c2_noe",   noe_a,    1);
    tick();                                       // cycle 3 TURN
    checkOutput("rd_c3_ale",   ale_a,    0);
    checkOutput("rd_c3_nme",   nme_a,    0);
    checkOutput("rd_c3_enb",   enb_a,    0);
    checkOutput("rd_c3_noe",   noe_a,    1);
    tick();                                       // cycle 4 ACCESS
    checkOutput("rd_c4_noe",   noe_a,    0);
    checkOutput("rd_c4_nwe",   nwe_a,    1);
    checkOutput("rd_c4_ack",   ack_a,    0);
    tick();                                       // cycle 5 DONE
    checkOutput("rd_c5_ack",   ack_a,    1);
    checkOutput("rd_c5_err",   err_a,    0);
    checkOutput("rd_c5_noe",   noe_a,    1);
    checkOutput("rd_c5_nme",   nme_a,    1);
    checkOutput("rd_c5_rdata", rdata_a,  16'hBEEF);
    tick();                                       // cycle 6 IDLE
    checkOutput("rd_c6_ack",   ack_a,    0);
    checkOutput("rd_c6_busy",  busy_a,   0);

    // ---------------- timeout, Ready held low ----------------
    ready_a = 1'b0;
    ad_in_a = 16'h1111;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0077, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("to_c%0d_noe", c), noe_a, (c >= 4 && c <= 8) ? 0 : 1);
      checkOutput($sformatf("to_c%0d_ack", c), ack_a, (c == 9) ? 1 : 0);
      checkOutput($sformatf("to_c%0d_err", c), err_a, (c == 9) ? 1 : 0);
    end
    checkOutput("to_rdata_kept", rdata_a, 16'hBEEF);

    // ---------------- read, Ready low for 3 ACCESS cycles ----------------
    ready_a = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("rl_c%0d_noe", c), noe_a, (c >= 4 && c <= 7) ? 0 : 1);
      checkOutput($sformatf("rl_c%0d_ack", c), ack_a, (c == 8) ? 1 : 0);
      ready_a = (c == 7);
      ad_in_a = 16'h1000 + 16'(c);
    end
    checkOutput("rl_rdata", rdata_a, 16'h1007);
    checkOutput("rl_err",   err_a,   0);
    ready_a = 1'b1;
    tick();

    // ---------------- back-to-back reads, Req held high ----------------
    b2b_addr[0] = 16'h0100;
    b2b_addr[1] = 16'h0200;
    b2b_addr[2] = 16'h0300;
    applyStimulus(1'b0, 1'b1, 1'b0, b2b_addr[0], 16'h0000);
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("bb_c%0d_ack", c), ack_a,
                  (c % 5 == 0 && c <= 15) ? 1 : 0);
      checkOutput($sformatf("bb_c%0d_ale", c), ale_a,
                  (c % 5 == 2 && c <= 12) ? 1 : 0);
      checkOutput($sformatf("bb_c%0d_busy", c), busy_a, (c <= 15) ? 1 : 0);
      if (c % 5 == 2 && c <= 12)
        checkOutput($sformatf("bb_c%0d_adout", c), ad_out_a, b2b_addr[(c - 2) / 5]);
      if (c == 1)  req_addr_a = b2b_addr[1];
      if (c == 6)  req_addr_a = b2b_addr[2];
      if (c == 11) req_a = 1'b0;
    end

    // ---------------- write, WAIT_STATES=2 ----------------
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h00A0, 16'h5A5A);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("wr_c%0d_enb", c), enb_b, (c <= 6) ? 1 : 0);
      checkOutput($sformatf("wr_c%0d_nwe", c), nwe_b, (c >= 4 && c <= 6) ? 0 : 1);
      checkOutput($sformatf("wr_c%0d_noe", c), noe_b, 1);
      checkOutput($sformatf("wr_c%0d_ack", c), ack_b, (c == 7) ? 1 : 0);
      if (c >= 3 && c <= 6)
        checkOutput($sformatf("wr_c%0d_adout", c), ad_out_b, 16'h5A5A);
    end

    // ---------------- reset during ACCESS of a write ----------------
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0033, 16'h1111);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick(); tick(); tick(); tick();               // cycle 5, second ACCESS
    checkOutput("ra_access_nwe", nwe_b, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("ra_nwe",  nwe_b,  1);
    checkOutput("ra_nme",  nme_b,  1);
    checkOutput("ra_enb",  enb_b,  0);
    checkOutput("ra_busy", busy_b, 0);
    checkOutput("ra_ack",  ack_b,  0);
    tick();
    checkOutput("ra_ack_after", ack_b, 0);

    // New read on dut_b completes normally (Ack at cycle 7 with W=2).
    ad_in_b = 16'hCAFE;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("nr_c%0d_ack", c), ack_b, (c == 7) ? 1 : 0);
      checkOutput($sformatf("nr_c%0d_noe", c), noe_b, (c >= 4 && c <= 6) ? 0 : 1);
    end
    checkOutput("nr_rdata", rdata_b, 16'hCAFE);
    checkOutput("nr_err",   err_b,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
